// File: rtl/canvas_write_scheduler.sv
// canvas_write_scheduler
//   Single write-port scheduler for the drawing canvases. Merges freehand tool
//   pixels and an internal layer-clear sweep onto one registered write bus,
//   one pixel per cycle. During a clear the tool may win at most TOOL_BURST
//   consecutive slots before a clear slot is forced, so a clear always ends.
//
// Ports:
//   clk           system clock (CLOCK_50 domain)
//   reset         asynchronous, active-low reset
//   tool_valid    tool has a pixel to write
//   tool_x/y      tool pixel coordinates
//   tool_color    tool pixel color
//   tool_ready    tool pixel accepted when tool_valid && tool_ready
//   active_layer  selected layer, 1..4 valid; other values select nothing
//   layer_enable  per-canvas visibility, bit k gates layer k+1
//   clear_req     request a clear of active_layer
//   wr_en         one-hot canvas write strobe, bit k = canvas k+1 (registered)
//   wr_x/y        write coordinates (registered, held between writes)
//   wr_color      write color (registered, held between writes)
//   busy          clear in progress (CLEAR or DONE)
//   clear_done    one-cycle pulse at clear completion
module canvas_write_scheduler #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int TOOL_BURST  = 2,
    parameter int COLOR_WIDTH = 8,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0,
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tool_valid,
    input  logic [XW-1:0]          tool_x,
    input  logic [YW-1:0]          tool_y,
    input  logic [COLOR_WIDTH-1:0] tool_color,
    output logic                   tool_ready,
    input  logic [2:0]             active_layer,
    input  logic [3:0]             layer_enable,
    input  logic                   clear_req,
    output logic [3:0]             wr_en,
    output logic [XW-1:0]          wr_x,
    output logic [YW-1:0]          wr_y,
    output logic [COLOR_WIDTH-1:0] wr_color,
    output logic                   busy,
    output logic                   clear_done
);

    localparam int SW = $clog2(TOOL_BURST + 1);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [SW-1:0] BURST  = SW'(TOOL_BURST);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               target_q, target_d;
    logic [XW-1:0]            cx_q, cx_d;
    logic [YW-1:0]            cy_q, cy_d;
    logic [SW-1:0]            streak_q, streak_d;
    logic [3:0]               wr_en_q, wr_en_d;
    logic [XW-1:0]            wr_x_q, wr_x_d;
    logic [YW-1:0]            wr_y_q, wr_y_d;
    logic [COLOR_WIDTH-1:0]   wr_color_q, wr_color_d;

    logic [3:0] tool_en;
    logic       tool_fire;

    // Layer number to canvas one-hot; out-of-range layers select nothing.
    function automatic logic [3:0] layer_onehot(input logic [2:0] layer);
        logic [3:0] oh;
        case (layer)
            3'd1:    oh = 4'b0001;
            3'd2:    oh = 4'b0010;
            3'd3:    oh = 4'b0100;
            3'd4:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Tool pixels only land on a visible, valid layer; otherwise they are dropped.
    assign tool_en    = layer_onehot(active_layer) & layer_enable;
    assign tool_ready = (state_q == StClear) ? (streak_q < BURST) : 1'b1;
    assign tool_fire  = tool_valid & tool_ready;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        streak_d   = streak_q;
        wr_en_d    = 4'b0000;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;

        case (state_q)
            StIdle, StDone: begin
                if (tool_fire && (tool_en != 4'b0000)) begin
                    wr_en_d    = tool_en;
                    wr_x_d     = tool_x;
                    wr_y_d     = tool_y;
                    wr_color_d = tool_color;
                end
                if (state_q == StDone) begin
                    state_d = StIdle;
                end else if (clear_req) begin
                    target_d = active_layer;
                    cx_d     = '0;
                    cy_d     = '0;
                    streak_d = '0;
                    // An invalid target still reports completion, with no writes.
                    state_d  = (layer_onehot(active_layer) != 4'b0000) ? StClear : StDone;
                end
            end

            StClear: begin
                if (tool_fire) begin
                    if (tool_en != 4'b0000) begin
                        wr_en_d    = tool_en;
                        wr_x_d     = tool_x;
                        wr_y_d     = tool_y;
                        wr_color_d = tool_color;
                    end
                    streak_d = streak_q + SW'(1);
                end else begin
                    // Clear writes ignore layer_enable: hidden layers are cleared too.
                    wr_en_d    = layer_onehot(target_q);
                    wr_x_d     = cx_q;
                    wr_y_d     = cy_q;
                    wr_color_d = COLOR_NONE;
                    streak_d   = '0;
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        if (cy_q == Y_LAST) begin
                            state_d = StDone;
                        end else begin
                            cy_d = cy_q + YW'(1);
                        end
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            target_q   <= 3'd0;
            cx_q       <= '0;
            cy_q       <= '0;
            streak_q   <= '0;
            wr_en_q    <= 4'b0000;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_color_q <= COLOR_NONE;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            streak_q   <= streak_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_color   = wr_color_q;
    assign busy       = (state_q != StIdle);
    assign clear_done = (state_q == StDone);

endmodule
